// File: rtl/counter_sched_pkg.sv
// Shared defaults and index helpers for the counter bank scheduler.
package counter_sched_pkg;

  localparam int unsigned DEF_NCH = 3;
  localparam int unsigned DEF_W   = 4;

  // Channel 0 occupies the LSBs: ch0=5, ch1=7, ch2=11.
  localparam logic [DEF_NCH*DEF_W-1:0] DEF_INIT = {4'd11, 4'd7, 4'd5};

  // Low bit position of channel idx inside a packed per-channel vector.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans requests from the pointer upward (mod N),
// grants the first one-hot, and advances the pointer past the winner.
module rr_arbiter #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_ptr_next;
  logic [N-1:0]  w_gnt;
  logic [IW-1:0] w_idx;
  logic          w_found;

  // Pick the first requester at or after the pointer, wrapping at N.
  always_comb begin
    int unsigned pos;
    w_gnt   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    pos     = 0;
    for (int unsigned off = 0; off < N; off++) begin
      pos = (int'(r_ptr) + off) % N;
      if (!w_found && i_req[pos[IW-1:0]]) begin
        w_found                = 1'b1;
        w_gnt[pos[IW-1:0]]     = 1'b1;
        w_idx                  = pos[IW-1:0];
      end
    end
  end

  // Pointer moves to the slot after the winner; holds when nothing is granted.
  always_comb begin
    w_ptr_next = r_ptr;
    if (w_found) begin
      w_ptr_next = (w_idx == IW'(N - 1)) ? '0 : w_idx + IW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_next;
    end
  end

  assign o_gnt   = w_gnt;
  assign o_idx   = w_idx;
  assign o_valid = w_found;

endmodule

// File: rtl/counter_bank_sched.sv
// Bank of NCH counters sharing a single incrementer. Loads always apply;
// one increment per cycle is granted round-robin among non-loading requesters.
// Optional build macro COUNTER_BANK_SATURATE_EN: increments saturate at
// all-ones (wrap then flags a saturated hit) instead of rolling over.
module counter_bank_sched
  import counter_sched_pkg::*;
#(
  parameter int unsigned         NCH  = DEF_NCH,
  parameter int unsigned         W    = DEF_W,
  parameter logic [NCH*W-1:0]    INIT = DEF_INIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic [NCH-1:0]   load_req,
  input  logic [NCH*W-1:0] load_val,
  input  logic [NCH-1:0]   inc_req,
  output logic [NCH-1:0]   inc_gnt,
  output logic [NCH*W-1:0] count,
  output logic [NCH-1:0]   wrap,
  output logic             busy
);

  localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH*W-1:0] r_count;
  logic [NCH-1:0]   r_wrap;
  logic             r_busy;

  logic [NCH-1:0]   w_elig;
  logic [NCH-1:0]   w_gnt;
  logic [IW-1:0]    w_idx;
  logic             w_valid;
  logic [W-1:0]     w_sel;
  logic [W-1:0]     w_sum;
  logic             w_at_max;
  logic [NCH*W-1:0] w_next_count;
  logic [NCH-1:0]   w_next_wrap;

  // Loading channels drop out of arbitration; halt removes everyone.
  always_comb begin
    w_elig = halt ? '0 : (inc_req & ~load_req);
  end

  rr_arbiter #(
    .N  (NCH),
    .IW (IW)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   (w_elig),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  // Shared adder: operand is the granted channel's current count.
  always_comb begin
    w_sel    = r_count[slice_lo(int'(w_idx), W) +: W];
    w_at_max = &w_sel;
`ifdef COUNTER_BANK_SATURATE_EN
    w_sum    = w_at_max ? w_sel : w_sel + W'(1);
`else
    w_sum    = w_sel + W'(1);
`endif
  end

  // Next counter values and wrap flags: load beats increment per channel.
  always_comb begin
    w_next_count = r_count;
    w_next_wrap  = '0;
    if (!halt) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (load_req[i]) begin
          w_next_count[slice_lo(i, W) +: W] = load_val[slice_lo(i, W) +: W];
        end else if (w_gnt[i]) begin
          w_next_count[slice_lo(i, W) +: W] = w_sum;
          w_next_wrap[i]                    = w_at_max;
        end
      end
    end
  end

  // Counter, wrap and busy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= INIT;
      r_wrap  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_wrap  <= w_next_wrap;
      r_busy  <= |w_gnt;
    end
  end

  assign inc_gnt = w_gnt;
  assign count   = r_count;
  assign wrap    = r_wrap;
  assign busy    = r_busy;

endmodule

// File: tb/tb_counter_bank_sched.sv
// Self-checking bench for counter_bank_sched (default parameters).
module tb_counter_bank_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic [2:0]  load_req;
  logic [11:0] load_val;
  logic [2:0]  inc_req;
  logic [2:0]  inc_gnt;
  logic [11:0] count;
  logic [2:0]  wrap;
  logic        busy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

`ifdef COUNTER_BANK_SATURATE_EN
  localparam logic [3:0] C1 = 4'hF;
  localparam logic [3:0] C2 = 4'hF;
`else
  localparam logic [3:0] C1 = 4'h0;
  localparam logic [3:0] C2 = 4'h0;
`endif

  typedef struct {
    string       name;
    logic        rst;
    logic        halt;
    logic [2:0]  lr;
    logic [11:0] lv;
    logic [2:0]  ir;
    logic [2:0]  gnt;
    logic [11:0] cnt;
    logic [2:0]  wrp;
    logic        b;
  } vec_t;

  typedef struct {
    string       name;
    logic [11:0] cnt;
    logic [2:0]  wrp;
    logic        b;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  counter_bank_sched dut (
    .clk      (clk),
    .rst      (rst),
    .halt     (halt),
    .load_req (load_req),
    .load_val (load_val),
    .inc_req  (inc_req),
    .inc_gnt  (inc_gnt),
    .count    (count),
    .wrap     (wrap),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string nm, logic r, logic h, logic [2:0] lr, logic [11:0] lv,
                              logic [2:0] ir, logic [2:0] g, logic [11:0] c, logic [2:0] wp,
                              logic b);
    vec_t v;
    v.name = nm; v.rst = r; v.halt = h; v.lr = lr; v.lv = lv; v.ir = ir;
    v.gnt = g; v.cnt = c; v.wrp = wp; v.b = b;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle, check the combinational grant, queue the registered
  // expectation and compare it once the edge has produced it.
  task automatic step(vec_t v);
    exp_t e;
    @(negedge clk);
    rst = v.rst; halt = v.halt; load_req = v.lr; load_val = v.lv; inc_req = v.ir;
    #1;
    chk({v.name, " gnt"}, 32'(inc_gnt), 32'(v.gnt));
    e.name = v.name; e.cnt = v.cnt; e.wrp = v.wrp; e.b = v.b;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({e.name, " count"}, 32'(count), 32'(e.cnt));
      chk({e.name, " wrap"},  32'(wrap),  32'(e.wrp));
      chk({e.name, " busy"},  32'(busy),  32'(e.b));
    end
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; load_req = '0; load_val = '0; inc_req = '0;

    // Reset held two cycles, then idle.
    tbl.push_back(mk("rst0",   1, 0, 3'b000, 12'h000, 3'b000, 3'b000, 12'hB75, 3'b000, 0));
    tbl.push_back(mk("rst1",   1, 0, 3'b000, 12'h000, 3'b000, 3'b000, 12'hB75, 3'b000, 0));
    tbl.push_back(mk("idle",   0, 0, 3'b000, 12'h000, 3'b000, 3'b000, 12'hB75, 3'b000, 0));
    // Fairness: all three requesting for six cycles.
    tbl.push_back(mk("fair0",  0, 0, 3'b000, 12'h000, 3'b111, 3'b001, 12'hB76, 3'b000, 1));
    tbl.push_back(mk("fair1",  0, 0, 3'b000, 12'h000, 3'b111, 3'b010, 12'hB86, 3'b000, 1));
    tbl.push_back(mk("fair2",  0, 0, 3'b000, 12'h000, 3'b111, 3'b100, 12'hC86, 3'b000, 1));
    tbl.push_back(mk("fair3",  0, 0, 3'b000, 12'h000, 3'b111, 3'b001, 12'hC87, 3'b000, 1));
    tbl.push_back(mk("fair4",  0, 0, 3'b000, 12'h000, 3'b111, 3'b010, 12'hC97, 3'b000, 1));
    tbl.push_back(mk("fair5",  0, 0, 3'b000, 12'h000, 3'b111, 3'b100, 12'hD97, 3'b000, 1));
    // Load on ch0 steals its slot; grant passes to ch1.
    tbl.push_back(mk("confl",  0, 0, 3'b001, 12'h002, 3'b011, 3'b010, 12'hDA2, 3'b000, 1));
    // Halt freezes everything, including loads; ptr is 2 here.
    tbl.push_back(mk("halt0",  0, 1, 3'b111, 12'h000, 3'b111, 3'b000, 12'hDA2, 3'b000, 0));
    tbl.push_back(mk("halt1",  0, 1, 3'b111, 12'h000, 3'b111, 3'b000, 12'hDA2, 3'b000, 0));
    tbl.push_back(mk("halt2",  0, 1, 3'b111, 12'h000, 3'b111, 3'b000, 12'hDA2, 3'b000, 0));
    tbl.push_back(mk("resume", 0, 0, 3'b000, 12'h000, 3'b111, 3'b100, 12'hEA2, 3'b000, 1));
    // ch1 loaded to 15 then incremented: wraps (or saturates).
    tbl.push_back(mk("ld15",   0, 0, 3'b010, 12'h0F0, 3'b000, 3'b000, 12'hEF2, 3'b000, 0));
    tbl.push_back(mk("wrap1",  0, 0, 3'b000, 12'h000, 3'b010, 3'b010, {4'hE, C1, 4'h2}, 3'b010, 1));
    tbl.push_back(mk("wclr",   0, 0, 3'b000, 12'h000, 3'b000, 3'b000, {4'hE, C1, 4'h2}, 3'b000, 0));
    // Load ch2=15 alongside an increment on ch0, then wrap ch2.
    tbl.push_back(mk("ld2inc0",0, 0, 3'b100, 12'hF00, 3'b001, 3'b001, {4'hF, C1, 4'h3}, 3'b000, 1));
    tbl.push_back(mk("wrap2",  0, 0, 3'b000, 12'h000, 3'b100, 3'b100, {C2, C1, 4'h3}, 3'b100, 1));
    // Sole requester also loading: no grant at all.
    tbl.push_back(mk("ldonly", 0, 0, 3'b001, 12'h009, 3'b001, 3'b000, {C2, C1, 4'h9}, 3'b000, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i]);
    end

    // Reset during a grant cycle: increment discarded, ptr back to 0.
    step(mk("pre_rst", 0, 0, 3'b000, 12'h000, 3'b001, 3'b001, {C2, C1, 4'hA}, 3'b000, 1));
    step(mk("mid_rst", 1, 0, 3'b000, 12'h000, 3'b111, 3'b010, 12'hB75, 3'b000, 0));
    step(mk("post_rst",0, 0, 3'b000, 12'h000, 3'b111, 3'b001, 12'hB76, 3'b000, 1));

    // Halt right after a wrap pulse clears wrap but holds counts.
    step(mk("ld15b",   0, 0, 3'b001, 12'h00F, 3'b000, 3'b000, 12'hB7F, 3'b000, 0));
    step(mk("wrap0",   0, 0, 3'b000, 12'h000, 3'b001, 3'b001,
`ifdef COUNTER_BANK_SATURATE_EN
            12'hB7F,
`else
            12'hB70,
`endif
            3'b001, 1));
    step(mk("haltw",   0, 1, 3'b000, 12'h000, 3'b111, 3'b000,
`ifdef COUNTER_BANK_SATURATE_EN
            12'hB7F,
`else
            12'hB70,
`endif
            3'b000, 0));

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
